// File: rtl/iiitb_sipo_deser.sv
// Serial-in / parallel-out deserializer.
// Collects WIDTH serial bits framed by frame_start into a word and hands it
// to a single-entry output buffer with a valid/ready handshake. A word that
// completes while the buffer is still occupied is dropped and flagged as an
// overrun. A frame_start that arrives in the middle of a frame restarts the
// frame and produces a one-cycle resync pulse.
module iiitb_sipo_deser #(
    parameter int WIDTH     = 8,     // bits per frame, 2..32
    parameter bit MSB_FIRST = 1'b1   // 1: first bit is the word MSB
) (
    input  logic             clk,
    input  logic             rst,          // async, active low
    input  logic             frame_start,
    input  logic             serial_in,
    input  logic             data_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic             resync,
    output logic [7:0]       frame_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q,   state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sr_q,      sr_d;
    logic [WIDTH-1:0] dout_q,    dout_d;
    logic             vld_q,     vld_d;
    logic             ovr_q,     ovr_d;
    logic             rsy_q,     rsy_d;
    logic [7:0]       cnt_q,     cnt_d;

    logic             word_done;
    logic [WIDTH-1:0] word_full;
    logic             take;
    logic             load;

    // Insert one bit into a partial word. MSB-first shifts left so the
    // earliest bit ends up at the top; LSB-first shifts right so the earliest
    // bit ends up at [0].
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                  input logic             b);
        if (MSB_FIRST) begin
            return {sr[WIDTH-2:0], b};
        end
        return {b, sr[WIDTH-1:1]};
    endfunction

    // The word as it stands once the current serial bit is included; only
    // meaningful on the cycle the last bit of a frame is sampled.
    assign word_full = shift_in(sr_q, serial_in);

    // Frame sequencer: start, shift, restart on mid-frame frame_start, finish.
    // The last-bit check comes before frame_start so a frame_start coinciding
    // with the final bit neither aborts the word nor opens a new frame.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        rsy_d     = 1'b0;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    sr_d      = shift_in({WIDTH{1'b0}}, serial_in);
                    bit_cnt_d = CW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == LAST_IDX) begin
                    word_done = 1'b1;
                    sr_d      = {WIDTH{1'b0}};
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (frame_start) begin
                    // Drop the partial word; this bit opens the new frame.
                    sr_d      = shift_in({WIDTH{1'b0}}, serial_in);
                    bit_cnt_d = CW'(1);
                    rsy_d     = 1'b1;
                end else begin
                    sr_d      = shift_in(sr_q, serial_in);
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                sr_d      = {WIDTH{1'b0}};
            end
        endcase
    end

    // Output buffer: consume on valid&ready, load a finished word when the
    // slot is free or being freed on this edge, otherwise record an overrun.
    always_comb begin
        take   = vld_q & data_ready;
        load   = word_done & (~vld_q | data_ready);
        dout_d = dout_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        ovr_d  = ovr_q;
        if (take) begin
            vld_d = 1'b0;
        end
        if (load) begin
            dout_d = word_full;
            vld_d  = 1'b1;
            cnt_d  = cnt_q + 8'd1;
        end
        // Clear first so a simultaneous overrun event wins.
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (word_done && !load) begin
            ovr_d = 1'b1;
        end
    end

    // All state, including the registered outputs, in one reset domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= {WIDTH{1'b0}};
            dout_q    <= {WIDTH{1'b0}};
            vld_q     <= 1'b0;
            ovr_q     <= 1'b0;
            rsy_q     <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            ovr_q     <= ovr_d;
            rsy_q     <= rsy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = vld_q;
    assign overrun    = ovr_q;
    assign resync     = rsy_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_iiitb_sipo_deser.sv
// Bench for iiitb_sipo_deser: directed scenarios plus random traffic, with
// two instances (8-bit MSB-first and 5-bit LSB-first) sharing one stimulus
// stream and each tracked by a frame-level reference model.
module tb_iiitb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start = 1'b0;
    logic       serial_in = 1'b0;
    logic       data_ready = 1'b0;
    logic       ovr_clr = 1'b0;

    logic [7:0] d8;
    logic       v8, o8, r8;
    logic [7:0] c8;
    logic [4:0] d5;
    logic       v5, o5, r5;
    logic [7:0] c5;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iiitb_sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .serial_in(serial_in),
        .data_ready(data_ready), .ovr_clr(ovr_clr),
        .data_out(d8), .data_valid(v8), .overrun(o8), .resync(r8), .frame_cnt(c8)
    );

    iiitb_sipo_deser #(.WIDTH(5), .MSB_FIRST(1'b0)) u_lsb5 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .serial_in(serial_in),
        .data_ready(data_ready), .ovr_clr(ovr_clr),
        .data_out(d5), .data_valid(v5), .overrun(o5), .resync(r5), .frame_cnt(c5)
    );

    // Reference model: the frame is the list of bits received so far; the
    // word is assembled arithmetically only when the list is complete.
    typedef struct {
        bit          in_frame;
        int          nbits;
        bit          bits [32];
        bit          vld;
        logic [31:0] word;
        bit          ovr;
        bit          rsy;
        int          cnt;
    } model_t;

    model_t m8, m5;

    function automatic model_t mreset();
        model_t r;
        r.in_frame = 0;
        r.nbits    = 0;
        for (int i = 0; i < 32; i++) r.bits[i] = 0;
        r.vld  = 0;
        r.word = '0;
        r.ovr  = 0;
        r.rsy  = 0;
        r.cnt  = 0;
        return r;
    endfunction

    function automatic model_t mstep(input model_t m, input int w, input bit msb,
                                     input bit fs, input bit si,
                                     input bit rdy, input bit clr);
        model_t      n;
        bit          done;
        logic [31:0] wd;
        n    = m;
        done = 0;
        wd   = '0;
        n.rsy = 0;
        if (!m.in_frame) begin
            if (fs) begin
                n.in_frame = 1;
                n.nbits    = 1;
                n.bits[0]  = si;
            end
        end else if (m.nbits == w - 1) begin
            n.bits[w-1] = si;
            done        = 1;
            n.in_frame  = 0;
            n.nbits     = 0;
        end else if (fs) begin
            n.nbits   = 1;
            n.bits[0] = si;
            n.rsy     = 1;
        end else begin
            n.bits[m.nbits] = si;
            n.nbits         = m.nbits + 1;
        end
        if (done) begin
            for (int i = 0; i < w; i++) begin
                if (n.bits[i]) wd = wd + (32'd1 << (msb ? (w - 1 - i) : i));
            end
        end
        if (m.vld && rdy) n.vld = 0;
        if (clr) n.ovr = 0;
        if (done) begin
            if (!m.vld || rdy) begin
                n.vld  = 1;
                n.word = wd;
                n.cnt  = (m.cnt + 1) % 256;
            end else begin
                n.ovr = 1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("vld8", 32'(v8), 32'(m8.vld));
        if (m8.vld) chk("dout8", 32'(d8), m8.word);
        chk("ovr8", 32'(o8), 32'(m8.ovr));
        chk("rsy8", 32'(r8), 32'(m8.rsy));
        chk("cnt8", 32'(c8), 32'(m8.cnt));
        chk("vld5", 32'(v5), 32'(m5.vld));
        if (m5.vld) chk("dout5", 32'(d5), m5.word);
        chk("ovr5", 32'(o5), 32'(m5.ovr));
        chk("rsy5", 32'(r5), 32'(m5.rsy));
        chk("cnt5", 32'(c5), 32'(m5.cnt));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dout8"}, 32'(d8), 32'd0);
        chk({tag, "_dout5"}, 32'(d5), 32'd0);
        chk({tag, "_vld"},   32'({v8, v5}), 32'd0);
        chk({tag, "_ovr"},   32'({o8, o5}), 32'd0);
        chk({tag, "_rsy"},   32'({r8, r5}), 32'd0);
        chk({tag, "_cnt"},   32'({c8, c5}), 32'd0);
    endtask

    // One clock: apply inputs, advance both models on the edge, compare after.
    task automatic cyc(input bit fs, input bit si, input bit rdy, input bit clr);
        frame_start = fs;
        serial_in   = si;
        data_ready  = rdy;
        ovr_clr     = clr;
        @(posedge clk);
        m8 = mstep(m8, 8, 1'b1, fs, si, rdy, clr);
        m5 = mstep(m5, 5, 1'b0, fs, si, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m8  = mreset();
        m5  = mreset();
        #1;
        check_zero("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Eight-bit frame, MSB first on the wire; rdy_last applies to the final bit.
    task automatic send8(input logic [7:0] w, input bit rdy, input bit rdy_last);
        logic [7:0] v;
        v = w;
        for (int i = 0; i < 8; i++) cyc(i == 0, v[7-i], (i == 7) ? rdy_last : rdy, 1'b0);
    endtask

    initial begin
        m8 = mreset();
        m5 = mreset();
        #12;
        do_reset();

        // Basic frame, latency and one-cycle valid pulse.
        send8(8'h0F, 1'b1, 1'b1);
        chk("f15_dout", 32'(d8), 32'h0F);
        chk("f15_vld",  32'(v8), 32'd1);
        chk("f15_cnt",  32'(c8), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("f15_vld_drop", 32'(v8), 32'd0);

        // Back-to-back frames with no gap.
        do_reset();
        send8(8'hFF, 1'b1, 1'b1);
        chk("b2b_ff", 32'(d8), 32'hFF);
        send8(8'h00, 1'b1, 1'b1);
        chk("b2b_00",  32'(d8), 32'h00);
        chk("b2b_vld", 32'(v8), 32'd1);
        chk("b2b_cnt", 32'(c8), 32'd2);
        chk("b2b_ovr", 32'(o8), 32'd0);

        // Overrun with a stalled consumer, then clear.
        do_reset();
        send8(8'hA5, 1'b0, 1'b0);
        send8(8'h3C, 1'b0, 1'b0);
        chk("ovr_hold", 32'(d8), 32'hA5);
        chk("ovr_set",  32'(o8), 32'd1);
        chk("ovr_cnt",  32'(c8), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clr", 32'(o8), 32'd0);

        // Full buffer freed on the same edge the next word completes.
        send8(8'h3C, 1'b0, 1'b1);
        chk("swap_dout", 32'(d8), 32'h3C);
        chk("swap_vld",  32'(v8), 32'd1);
        chk("swap_ovr",  32'(o8), 32'd0);
        chk("swap_cnt",  32'(c8), 32'd2);

        // Mid-frame restart.
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        begin
            logic [7:0] w81;
            w81 = 8'h81;
            for (int i = 0; i < 8; i++) begin
                cyc(i == 0, w81[7-i], 1'b1, 1'b0);
                if (i == 0) chk("rsy_pulse", 32'(r8), 32'd1);
                if (i == 1) chk("rsy_clear", 32'(r8), 32'd0);
                if (i < 7)  chk("rsy_noword", 32'(v8), 32'd0);
            end
        end
        chk("rsy_dout", 32'(d8), 32'h81);
        chk("rsy_cnt",  32'(c8), 32'd1);

        // Final-bit frame_start does not open a new frame.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(i == 0 || i == 7, 1'b1, 1'b1, 1'b0);
        chk("fs_last_rsy", 32'(r8), 32'd0);
        chk("fs_last_dout", 32'(d8), 32'hFF);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("fs_last_cnt", 32'(c8), 32'd1);

        // Reset mid-frame, then free-running serial data without frame_start.
        do_reset();
        send8(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(i == 0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        m8  = mreset();
        m5  = mreset();
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0);
            check_zero("idle_after_rst");
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 5) == 0, 1'($urandom),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/iiitb_sipo_deser.md
IIITB_SIPO_DESER -- requirements
Module: iiitb_sipo_deser

Interface
REQ-001 Parameter: WIDTH, 8, bits per serial frame; legal range 2..32.
REQ-002 Parameter: MSB_FIRST, 1, 1 = first received bit is word MSB; 0 = first bit is LSB.
REQ-003 Port: clk  input  1  single rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-low reset.
REQ-005 Port: frame_start  input  1  high in the same cycle as the first serial bit of a frame.
REQ-006 Port: serial_in  input  1  serial data, one bit per clk; from upstream PISO data_out.
REQ-007 Port: data_ready  input  1  downstream accepts the output word when high with data_valid.
REQ-008 Port: ovr_clr  input  1  synchronous clear of the overrun flag.
REQ-009 Port: data_out  output  WIDTH  assembled parallel word; stable while data_valid=1.
REQ-010 Port: data_valid  output  1  output word available.
REQ-011 Port: overrun  output  1  sticky flag: completed word dropped because the output buffer was full.
REQ-012 Port: resync  output  1  one-cycle pulse: frame_start arrived mid-frame.
REQ-013 Port: frame_cnt  output  8  count of words accepted into the output buffer; wraps 255->0.

Function
REQ-014 FSM states: IDLE, SHIFT; transitions occur only on rising clk edges.
REQ-015 IDLE: frame_start=1 -> sample serial_in as bit 0, bit_cnt=1, go to SHIFT; frame_start=0 -> ignore serial_in, stay in IDLE.
REQ-016 SHIFT: each cycle -> sample serial_in into the shift register, bit_cnt+1.
REQ-017 Bit placement: MSB_FIRST=1 -> shift left, new bit enters at [0]; MSB_FIRST=0 -> shift right, new bit enters at [WIDTH-1].
REQ-018 Frame completes on the cycle the WIDTH-th bit is sampled; that edge transfers the word to the output buffer and returns the FSM to IDLE.
REQ-019 Latency: frame_start in cycle N -> data_valid=1 and data_out valid from cycle N+WIDTH (one edge after the last bit).
REQ-020 Back-to-back frames: frame_start in the cycle immediately after the last bit is legal; no dead cycle is required.
REQ-021 Handshake: data_valid=1 and data_ready=1 on an edge -> word consumed; data_valid falls next cycle unless a new word loads on the same edge.
REQ-022 Word completes while buffer empty, or full and data_ready=1 on the same edge -> new word loads, data_valid=1, frame_cnt+1, no overrun.
REQ-023 Word completes while buffer full and data_ready=0 -> new word dropped, buffer unchanged, overrun set to 1, frame_cnt unchanged.
REQ-024 frame_start=1 in SHIFT -> partial word discarded, current serial_in taken as bit 0, bit_cnt=1, resync=1 for exactly one cycle.
REQ-025 frame_start=1 in SHIFT on the cycle the WIDTH-th bit arrives -> frame completes normally; no resync; the next frame starts only on a later frame_start.
REQ-026 overrun stays set until ovr_clr=1 or reset; an overrun event in the same cycle as ovr_clr=1 -> overrun remains 1 (set wins).
REQ-027 data_out is held while data_valid=1 and data_ready=0; it never changes mid-handshake.

Reset
REQ-028 rst=0 asynchronously forces: FSM=IDLE, bit_cnt=0, shift register=0, data_out=0, data_valid=0, overrun=0, resync=0, frame_cnt=0.
REQ-029 Reset during SHIFT discards the partial frame; after rst rises, the block ignores serial_in until the next frame_start.
REQ-030 Reset removal is synchronous to clk; the first functional edge is the first rising clk edge with rst=1.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, data_ready=1; serial 0,0,0,0,1,1,1,1 with frame_start on bit 0 -> data_out=8'd15, data_valid=1 for one cycle at N+8, frame_cnt=1.
REQ-032 Back-to-back frames 8'd255 then 8'd0 with no gap, data_ready=1 -> data_out 8'hFF then 8'h00 on consecutive valid windows 8 cycles apart, frame_cnt=2, overrun=0.
REQ-033 data_ready=0; send 8'hA5 then 8'h3C -> data_out stays 8'hA5, overrun=1, frame_cnt=1; then ovr_clr=1 -> overrun=0.
REQ-034 Buffer full, data_ready=1 on the edge 8'h3C completes -> data_out=8'h3C, data_valid stays 1, overrun=0, frame_cnt=2.
REQ-035 frame_start reasserted after 3 bits, then 8 bits of 8'h81 -> resync pulse of 1 cycle, data_out=8'h81, no word for the aborted frame.
REQ-036 rst=0 after 5 bits of a frame, released, serial_in toggling with no frame_start for 20 cycles -> all outputs 0, data_valid never asserts.
